// File: rtl/bp_perf_monitor.sv
// Branch-prediction performance monitor: samples core debug outputs each cycle,
// keeps saturating event counters, sticky saturation flags and the last flush PC.
module bp_perf_monitor #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        rst_out,
    input  logic        hit_2,
    input  logic        stall_2,
    input  logic [31:0] inst_2,
    input  logic [31:0] pc_2,
    input  logic        rd_req,
    input  logic [2:0]  rd_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data
);

    localparam int NUM_CNT = 6;
    localparam int EV_CYC  = 0;
    localparam int EV_STL  = 1;
    localparam int EV_BR   = 2;
    localparam int EV_JMP  = 3;
    localparam int EV_FLU  = 4;
    localparam int EV_HIT  = 5;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0] sticky_q, sticky_d;
    logic [31:0]        flush_pc_q, flush_pc_d;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic [NUM_CNT-1:0] ev;
    logic [6:0]         opcode;
    logic               is_br, is_jmp;
    logic [31:0]        cnt_ext [NUM_CNT];

    // Only the opcode field matters for event decode.
    logic unused_inst_hi;
    assign unused_inst_hi = ^inst_2[31:7];

    assign opcode = inst_2[6:0];
    assign is_br  = (opcode == OP_BRANCH);
    assign is_jmp = (opcode == OP_JAL) || (opcode == OP_JALR);

    always_comb begin
        ev         = '0;
        ev[EV_CYC] = en;
        ev[EV_STL] = en && stall_2;
        ev[EV_BR]  = en && !stall_2 && is_br;
        ev[EV_JMP] = en && !stall_2 && is_jmp;
        ev[EV_FLU] = en && rst_out;
        ev[EV_HIT] = en && hit_2 && !stall_2;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sticky_d = sticky_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (ev[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            sticky_d[i] = !clr && (sticky_q[i] || (cnt_d[i] == CNT_MAX));
        end

        flush_pc_d = flush_pc_q;
        if (clr) begin
            flush_pc_d = '0;
        end else if (ev[EV_FLU]) begin
            flush_pc_d = pc_2;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_ext[i]            = '0;
            cnt_ext[i][CNT_W-1:0] = cnt_q[i];
        end
    end

    // Read mux looks at current state, so the returned value excludes this cycle's event.
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_data_q;
        if (rd_req) begin
            case (rd_addr)
                3'd0:    rd_data_d = cnt_ext[EV_CYC];
                3'd1:    rd_data_d = cnt_ext[EV_STL];
                3'd2:    rd_data_d = cnt_ext[EV_BR];
                3'd3:    rd_data_d = cnt_ext[EV_JMP];
                3'd4:    rd_data_d = cnt_ext[EV_FLU];
                3'd5:    rd_data_d = cnt_ext[EV_HIT];
                3'd6:    rd_data_d = flush_pc_q;
                default: rd_data_d = {26'b0, sticky_q};
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counters are a handful of flops, not a RAM, so they are reset element by element.
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            sticky_q   <= '0;
            flush_pc_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sticky_q   <= sticky_d;
            flush_pc_q <= flush_pc_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Directed bench for bp_perf_monitor: a 32-bit and a 4-bit instance share stimulus,
// read-back expectations come from a hand-computed table plus corner-case sequences.
module tb_bp_perf_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, clr, rst_out, hit_2, stall_2;
    logic [31:0] inst_2, pc_2;
    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        rd_valid, rd_valid4;
    logic [31:0] rd_data, rd_data4;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BEQ  = 32'h0020_8463;
    localparam logic [31:0] JAL0 = 32'h0000_006F;
    localparam logic [31:0] JAL1 = 32'h0000_00EF;
    localparam logic [31:0] JALR = 32'h0000_8067;

    typedef struct {
        int          phase;
        logic [2:0]  addr;
        logic [31:0] exp;
        logic [31:0] exp4;
    } vec_t;

    vec_t tbl[$];

    bp_perf_monitor #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .rst_out(rst_out),
        .hit_2(hit_2), .stall_2(stall_2), .inst_2(inst_2), .pc_2(pc_2),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    bp_perf_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .rst_out(rst_out),
        .hit_2(hit_2), .stall_2(stall_2), .inst_2(inst_2), .pc_2(pc_2),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid4), .rd_data(rd_data4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input int p, input logic [2:0] a, input logic [31:0] e, input logic [31:0] e4);
        vec_t v;
        v.phase = p; v.addr = a; v.exp = e; v.exp4 = e4;
        tbl.push_back(v);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] e, input logic [31:0] e4,
                           input string nm);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        check({nm, ".valid"}, {31'b0, rd_valid}, 32'd1);
        check({nm, ".valid4"}, {31'b0, rd_valid4}, 32'd1);
        check(nm, rd_data, e);
        check({nm, ".w4"}, rd_data4, e4);
    endtask

    task automatic apply_phase(input int p);
        foreach (tbl[i]) begin
            if (tbl[i].phase == p)
                do_read(tbl[i].addr, tbl[i].exp, tbl[i].exp4,
                        $sformatf("p%0d.addr%0d", p, tbl[i].addr));
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Phase 0: 10 idle cycles
        for (int a = 0; a < 8; a++) add(0, 3'(a), (a == 0) ? 32'd10 : 32'd0, (a == 0) ? 32'd10 : 32'd0);
        // Phase 1: 4 beq, 2 stalled beq; 4-bit cyc saturates
        add(1, 3'd0, 32'd16, 32'd15);
        add(1, 3'd1, 32'd2, 32'd2);
        add(1, 3'd2, 32'd4, 32'd4);
        add(1, 3'd3, 32'd0, 32'd0);
        add(1, 3'd7, 32'h00, 32'h01);
        // Phase 2: two flushes
        add(2, 3'd4, 32'd2, 32'd2);
        add(2, 3'd6, 32'h88, 32'h88);
        add(2, 3'd0, 32'd19, 32'd15);
        // Phase 3: 20 hit cycles
        add(3, 3'd5, 32'd20, 32'd15);
        add(3, 3'd7, 32'h00, 32'h21);
        add(3, 3'd0, 32'd39, 32'd15);
        // Phase 4: 5 more hits, saturated counter stays put
        add(4, 3'd5, 32'd25, 32'd15);
        add(4, 3'd7, 32'h00, 32'h21);
        add(4, 3'd0, 32'd44, 32'd15);
        // Phase 5: jal, jal, jalr
        add(5, 3'd3, 32'd3, 32'd3);
        add(5, 3'd0, 32'd47, 32'd15);
        // Phase 6: everything zero (after clr, and again after mid-run reset)
        for (int a = 0; a < 8; a++) add(6, 3'(a), 32'd0, 32'd0);
        // Phase 7: one jal after clr
        add(7, 3'd0, 32'd1, 32'd1);
        add(7, 3'd3, 32'd1, 32'd1);
        add(7, 3'd2, 32'd0, 32'd0);
        add(7, 3'd7, 32'd0, 32'd0);
        // Phase 8: clr with en = 0
        add(8, 3'd0, 32'd0, 32'd0);
        add(8, 3'd3, 32'd0, 32'd0);

        rst = 1'b1; en = 1'b0; clr = 1'b0; rst_out = 1'b0; hit_2 = 1'b0; stall_2 = 1'b0;
        inst_2 = '0; pc_2 = '0; rd_req = 1'b0; rd_addr = '0;
        run(2);
        check("reset.valid", {31'b0, rd_valid}, 32'd0);
        check("reset.data", rd_data, 32'd0);
        rst = 1'b0;
        run(1);

        en = 1'b1; run(10); en = 1'b0;
        apply_phase(0);

        en = 1'b1; inst_2 = BEQ; run(4);
        stall_2 = 1'b1; run(2);
        en = 1'b0; stall_2 = 1'b0; inst_2 = '0;
        apply_phase(1);

        en = 1'b1;
        rst_out = 1'b1; pc_2 = 32'h40; run(1);
        rst_out = 1'b0; pc_2 = 32'h64; run(1);
        rst_out = 1'b1; pc_2 = 32'h88; run(1);
        rst_out = 1'b0; pc_2 = '0; en = 1'b0;
        apply_phase(2);

        en = 1'b1; hit_2 = 1'b1; run(20); en = 1'b0; hit_2 = 1'b0;
        apply_phase(3);
        en = 1'b1; hit_2 = 1'b1; run(5); en = 1'b0; hit_2 = 1'b0;
        apply_phase(4);

        en = 1'b1;
        inst_2 = JAL0; run(1);
        inst_2 = JAL1; run(1);
        inst_2 = JALR; run(1);
        en = 1'b0; inst_2 = '0;
        apply_phase(5);

        // clr in the same cycle as a jal event, with a read of jmp in flight
        en = 1'b1; inst_2 = JAL0; clr = 1'b1; rd_req = 1'b1; rd_addr = 3'd3;
        @(negedge clk);
        en = 1'b0; inst_2 = '0; clr = 1'b0; rd_req = 1'b0;
        check("clr.read.valid", {31'b0, rd_valid}, 32'd1);
        check("clr.read.jmp", rd_data, 32'd3);
        check("clr.read.jmp.w4", rd_data4, 32'd3);
        apply_phase(6);

        en = 1'b1; inst_2 = JAL0; run(1); en = 1'b0; inst_2 = '0;
        apply_phase(7);

        clr = 1'b1; run(1); clr = 1'b0;
        apply_phase(8);

        // read in an event cycle returns the pre-update value
        en = 1'b1; rd_req = 1'b1; rd_addr = 3'd0;
        @(negedge clk);
        en = 1'b0; rd_req = 1'b0;
        check("evread.cyc", rd_data, 32'd0);

        // back-to-back reads, then rd_data holds once rd_valid drops
        rd_req = 1'b1; rd_addr = 3'd3;
        @(negedge clk);
        check("b2b.first.valid", {31'b0, rd_valid}, 32'd1);
        check("b2b.first.jmp", rd_data, 32'd0);
        rd_addr = 3'd0;
        @(negedge clk);
        rd_req = 1'b0;
        check("b2b.second.valid", {31'b0, rd_valid}, 32'd1);
        check("b2b.second.cyc", rd_data, 32'd1);
        @(negedge clk);
        check("hold.valid", {31'b0, rd_valid}, 32'd0);
        check("hold.data", rd_data, 32'd1);

        // mid-run asynchronous reset with a read pending
        en = 1'b1; hit_2 = 1'b1; run(3); en = 1'b0; hit_2 = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd0;
        #1 rst = 1'b1;
        #1;
        check("midrst.async.data", rd_data, 32'd0);
        check("midrst.async.valid", {31'b0, rd_valid}, 32'd0);
        @(negedge clk);
        check("midrst.no_pulse", {31'b0, rd_valid}, 32'd0);
        rd_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("midrst.after.valid", {31'b0, rd_valid}, 32'd0);
        apply_phase(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_perf_monitor.md
# bp_perf_monitor

Branch-prediction performance monitor that sits directly downstream of the pipelined CPU core. It samples the core's debug outputs every cycle (flush pulse, predictor hit, stall, stage-3 instruction and PC) and accumulates saturating event counters plus a last-flush-PC capture. Software or the testbench reads the results through a one-cycle request/valid read port. The block is purely observational and never back-pressures the core.

## Interface
Parameters:
- CNT_W, 32: counter width (1..32); read data is zero-extended to 32 bits.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; when 0, counters and capture hold their values.
- clr  in  1  synchronous clear of all counters, the capture register and the sticky bits.
- rst_out  in  1  core pipeline flush, i.e. a mispredict or redirect.
- hit_2  in  1  predictor hit from the fetch stage.
- stall_2  in  1  core stall.
- inst_2  in  32  stage-3 (execute) instruction.
- pc_2  in  32  stage-3 PC.
- rd_req  in  1  read request (single-cycle strobe).
- rd_addr  in  3  counter select.
- rd_valid  out  1  read data valid.
- rd_data  out  32  read data.

## Operation
Event decode is combinational on the current-cycle inputs, gated by en:
- cyc: every cycle.
- stl: stall_2 = 1.
- br: stall_2 = 0 and inst_2[6:0] = 7'b1100011 (B-type).
- jmp: stall_2 = 0 and inst_2[6:0] is 7'b1101111 or 7'b1100111.
- flu: rst_out = 1. Each high cycle counts once.
- hit: hit_2 = 1 and stall_2 = 0.

Counter behaviour:
- Counters increment by 1 per event cycle.
- Counters saturate at 2^CNT_W−1 and never wrap.
- When a counter reaches its maximum, its sticky bit sets.

Capture register:
- On a flu event, the capture register loads pc_2.

Read map (rd_addr):
- 0: cyc
- 1: stl
- 2: br
- 3: jmp
- 4: flu
- 5: hit
- 6: last flush PC (32 bits, independent of CNT_W)
- 7: status, {26'b0, sat_hit, sat_flu, sat_jmp, sat_br, sat_stl, sat_cyc}

Precedence and boundary cases:
- clr beats any same-cycle increment. After clr, every counter is 0 and the next cycle's events count normally.
- clr and en = 0 in the same cycle: the clear still happens.
- en = 0: rd still works, and sticky bits hold.
- inst_2 = 0 (a flushed bubble) decodes as no br and no jmp.
- rd_req during clr: the read returns the pre-clear value.

## Timing
- Reset (asynchronous): all counters, the capture register and the sticky bits go to 0, rd_valid = 0, rd_data = 0.
- Reset asserted mid-operation clears everything immediately. There is no partial state.
- Counters update on the rising clk edge after the event cycle.
- Read latency is 1 cycle. rd_req sampled at edge N produces rd_valid = 1 for exactly the cycle after edge N.
- rd_data holds the register value from before edge N's update, i.e. it excludes that cycle's event.
- When rd_valid = 0, rd_data keeps its last value.
- Back-to-back rd_req is allowed: one result per cycle, in order.
- There is no ready signal; the consumer must accept rd_valid when it appears.

## Test plan
- Reset, then 10 idle cycles with en = 1 and inst_2 = 0 -> read addr 0 = 10; addrs 1–5 = 0; addr 6 = 0.
- 4 cycles with inst_2 = 0x00208463 (beq), stall_2 = 0, then 2 cycles of beq with stall_2 = 1 -> br = 4, stl = 2.
- rst_out pulsed for 1 cycle with pc_2 = 0x00000040, then for 1 cycle with pc_2 = 0x00000088 -> flu = 2, addr 6 = 0x00000088.
- CNT_W = 4: hit_2 = 1 for 20 cycles -> hit = 15, addr 7 bit 5 = 1, and the value stays 15.
- clr asserted in the same cycle as a jal event, with jmp = 3 beforehand -> jmp = 0 afterwards; rd_req in the clr cycle returns 3.
- Reset asserted mid-run with nonzero counters and rd_req pending -> all reads after release return 0, and no rd_valid pulse is emitted for the pre-reset request.
